dom_and_seq: RTL and testbench

DOM_AND_SEQ -- requirements
Module: dom_and_seq

---
 rtl/dom_seq_pkg.sv | 21 ++
 rtl/dom_and_d1_slice.sv | 42 ++++
 rtl/dom_and_seq.sv | 121 ++++++++++++
 tb/tb_dom_and_seq.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dom_seq_pkg.sv
// rtl/dom_seq_pkg.sv - shared types, LFSR constants and step function for the DOM AND sequencer
package dom_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CROSS   = 2'd1,
    COMBINE = 2'd2,
    OUT     = 2'd3
  } state_t;

  localparam int LFSR_W = 32;
  localparam int TAP_A  = 31;
  localparam int TAP_B  = 21;
  localparam int TAP_C  = 1;
  localparam int TAP_D  = 0;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
  endfunction

endpackage

// File: rtl/dom_and_d1_slice.sv
// rtl/dom_and_d1_slice.sv - one-bit first-order DOM AND gadget with registered cross terms and output shares
module dom_and_d1_slice (
  input  logic clk,
  input  logic rst,
  input  logic cross_en,
  input  logic capture_en,
  input  logic clear,
  input  logic a_s0,
  input  logic a_s1,
  input  logic b_s0,
  input  logic b_s1,
  input  logic r,
  output logic c_s0,
  output logic c_s1
);

  logic cross_0_q;
  logic cross_1_q;

  // Cross-domain products are blinded by r before they are ever stored.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cross_0_q <= 1'b0;
      cross_1_q <= 1'b0;
    end else if (cross_en) begin
      cross_0_q <= (a_s0 & b_s1) ^ r;
      cross_1_q <= (a_s1 & b_s0) ^ r;
    end
  end

  // Each output share mixes only its own domain's inner term with a registered cross term.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      c_s0 <= 1'b0;
      c_s1 <= 1'b0;
    end else if (capture_en) begin
      c_s0 <= (a_s0 & b_s0) ^ cross_0_q;
      c_s1 <= (a_s1 & b_s1) ^ cross_1_q;
    end
  end

endmodule

// File: rtl/dom_and_seq.sv
// rtl/dom_and_seq.sv - sequencer around W DOM AND slices with seeded LFSR randomness and valid/ready handshakes
module dom_and_seq
  import dom_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          seed_valid,
  input  logic [31:0]   seed,
  output logic          seed_ready,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a_s0,
  input  logic [W-1:0]  a_s1,
  input  logic [W-1:0]  b_s0,
  input  logic [W-1:0]  b_s1,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  c_s0,
  output logic [W-1:0]  c_s1,
  output logic          busy
);

  state_t              state;
  state_t              state_d;
  logic                seeded;
  logic [LFSR_W-1:0]   lfsr;
  logic [LFSR_W-1:0]   lfsr_adv;
  logic [W-1:0]        op_a_s0;
  logic [W-1:0]        op_a_s1;
  logic [W-1:0]        op_b_s0;
  logic [W-1:0]        op_b_s1;
  logic                seed_fire;
  logic                in_fire;
  logic                out_fire;

  assign seed_fire = seed_valid & seed_ready;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (in_fire) state_d = CROSS;
      CROSS:   state_d = COMBINE;
      COMBINE: state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A pending seed blocks operand acceptance so the seed always wins in IDLE.
  always_comb begin
    seed_ready = (state == IDLE);
    in_ready   = (state == IDLE) & seeded & ~seed_valid;
    out_valid  = (state == OUT);
    busy       = (state != IDLE);
  end

  always_comb begin
    lfsr_adv = lfsr;
    for (int i = 0; i < W; i++) begin
      lfsr_adv = lfsr_step(lfsr_adv);
    end
  end

  // A zero seed would lock the LFSR, so it is consumed but otherwise ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr   <= '0;
      seeded <= 1'b0;
    end else if (seed_fire && (seed != 32'd0)) begin
      lfsr   <= seed;
      seeded <= 1'b1;
    end else if (state == CROSS) begin
      lfsr   <= lfsr_adv;
    end
  end

  // Operand shares are precharged to zero once the gadget has consumed them.
  always_ff @(posedge clk) begin
    if (rst || (state == COMBINE)) begin
      op_a_s0 <= '0;
      op_a_s1 <= '0;
      op_b_s0 <= '0;
      op_b_s1 <= '0;
    end else if (in_fire) begin
      op_a_s0 <= a_s0;
      op_a_s1 <= a_s1;
      op_b_s0 <= b_s0;
      op_b_s1 <= b_s1;
    end
  end

  for (genvar i = 0; i < W; i++) begin : g_slice
    dom_and_d1_slice u_slice (
      .clk        (clk),
      .rst        (rst),
      .cross_en   (state == CROSS),
      .capture_en (state == COMBINE),
      .clear      (out_fire),
      .a_s0       (op_a_s0[i]),
      .a_s1       (op_a_s1[i]),
      .b_s0       (op_b_s0[i]),
      .b_s1       (op_b_s1[i]),
      .r          (lfsr[i]),
      .c_s0       (c_s0[i]),
      .c_s1       (c_s1[i])
    );
  end

endmodule

// File: tb/tb_dom_and_seq.sv
// tb/tb_dom_and_seq.sv - directed and table-driven self-checking bench for dom_and_seq
module tb_dom_and_seq;

  localparam int W = 8;

  logic          clk;
  logic          rst;
  logic          seed_valid;
  logic [31:0]   seed;
  logic          seed_ready;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a_s0;
  logic [W-1:0]  a_s1;
  logic [W-1:0]  b_s0;
  logic [W-1:0]  b_s1;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  c_s0;
  logic [W-1:0]  c_s1;
  logic          busy;

  dom_and_seq #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .seed_valid (seed_valid),
    .seed       (seed),
    .seed_ready (seed_ready),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_s0       (a_s0),
    .a_s1       (a_s1),
    .b_s0       (b_s0),
    .b_s1       (b_s1),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .c_s0       (c_s0),
    .c_s1       (c_s1),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a0;
    logic [W-1:0] a1;
    logic [W-1:0] b0;
    logic [W-1:0] b1;
    logic [W-1:0] exp_c;
    int           hold;
  } vec_t;

  vec_t         vecs [7];
  int           n_checks = 0;
  int           n_fail = 0;
  logic [31:0]  model;
  logic [31:0]  prev_lfsr;
  logic         have_prev;

  function automatic logic [31:0] tb_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send_seed(input logic [31:0] s);
    int waits;
    seed_valid = 1'b1;
    seed = s;
    waits = 0;
    #1;
    while (!seed_ready && waits < 20) begin
      tick();
      waits++;
    end
    check("seed_ready_wait", 32'(seed_ready), 32'd1);
    tick();
    seed_valid = 1'b0;
    if (s != 32'd0) begin
      model = s;
      have_prev = 1'b0;
    end
  endtask

  task automatic run_op(input logic [W-1:0] a0, input logic [W-1:0] a1,
                        input logic [W-1:0] b0, input logic [W-1:0] b1,
                        input logic [W-1:0] exp_c, input int hold, output int waits);
    logic [W-1:0] r;
    logic [W-1:0] e0;
    logic [W-1:0] e1;
    logic [W-1:0] h0;
    logic [W-1:0] h1;
    int lat;
    a_s0 = a0; a_s1 = a1; b_s0 = b0; b_s1 = b1;
    in_valid = 1'b1;
    waits = 0;
    #1;
    while (!in_ready && waits < 20) begin
      tick();
      waits++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    tick();
    in_valid = 1'b0;
    a_s0 = ~a0; a_s1 = ~a1; b_s0 = ~b0; b_s1 = ~b1;
    check("busy_after_accept", 32'(busy), 32'd1);
    check("lfsr_in_cross", dut.lfsr, model);
    if (have_prev) check("lfsr_fresh", 32'(dut.lfsr != prev_lfsr), 32'd1);
    prev_lfsr = dut.lfsr;
    have_prev = 1'b1;
    r  = model[W-1:0];
    e0 = (a0 & b0) ^ (a0 & b1) ^ r;
    e1 = (a1 & b1) ^ (a1 & b0) ^ r;
    for (int i = 0; i < W; i++) model = tb_step(model);
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check("latency", 32'(lat), 32'd3);
    check("c_unmask", 32'(c_s0 ^ c_s1), 32'(exp_c));
    check("c_s0_share", 32'(c_s0), 32'(e0));
    check("c_s1_share", 32'(c_s1), 32'(e1));
    check("operands_precharged",
          32'(dut.op_a_s0 | dut.op_a_s1 | dut.op_b_s0 | dut.op_b_s1), 32'd0);
    check("in_ready_in_out", 32'(in_ready), 32'd0);
    h0 = c_s0;
    h1 = c_s1;
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_shares", {16'd0, c_s0, c_s1}, {16'd0, h0, h1});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_c_cleared", {16'd0, c_s0, c_s1}, 32'd0);
  endtask

  initial begin
    int waits;
    rst = 1'b0; seed_valid = 1'b0; seed = '0; in_valid = 1'b0; out_ready = 1'b0;
    a_s0 = '0; a_s1 = '0; b_s0 = '0; b_s1 = '0;
    model = '0; prev_lfsr = '0; have_prev = 1'b0;

    vecs[0] = '{8'h0F, 8'h55, 8'h33, 8'hF0, 8'h42, 0};
    vecs[1] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 0};
    vecs[2] = '{8'h00, 8'h00, 8'hAA, 8'h55, 8'h00, 0};
    vecs[3] = '{8'hF0, 8'h0F, 8'h3C, 8'h00, 8'h3C, 5};
    vecs[4] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h26, 0};
    vecs[5] = '{8'h80, 8'h00, 8'h01, 8'h81, 8'h80, 2};
    vecs[6] = '{8'hC3, 8'h3C, 8'h69, 8'h00, 8'h69, 0};

    tick();
    do_reset();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_seed_ready", 32'(seed_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_c", {16'd0, c_s0, c_s1}, 32'd0);

    // Operands offered without a seed must never be taken.
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("unseeded_in_ready", 32'(in_ready), 32'd0);
      check("unseeded_busy", 32'(busy), 32'd0);
    end
    in_valid = 1'b0;

    send_seed(32'h0);
    check("zero_seed_seeded", 32'(dut.seeded), 32'd0);
    check("zero_seed_lfsr", dut.lfsr, 32'd0);
    check("zero_seed_in_ready", 32'(in_ready), 32'd0);

    // Seed and operands together: seed wins, operands go next cycle.
    seed_valid = 1'b1; seed = 32'h1; in_valid = 1'b1;
    a_s0 = vecs[0].a0; a_s1 = vecs[0].a1; b_s0 = vecs[0].b0; b_s1 = vecs[0].b1;
    #1;
    check("prio_in_ready", 32'(in_ready), 32'd0);
    tick();
    seed_valid = 1'b0;
    model = 32'h1;
    check("prio_seeded", 32'(dut.seeded), 32'd1);
    check("prio_still_idle", 32'(busy), 32'd0);
    run_op(vecs[0].a0, vecs[0].a1, vecs[0].b0, vecs[0].b1, vecs[0].exp_c, vecs[0].hold, waits);
    check("prio_accept_next", 32'(waits), 32'd0);

    for (int i = 1; i < 7; i++) begin
      run_op(vecs[i].a0, vecs[i].a1, vecs[i].b0, vecs[i].b1, vecs[i].exp_c, vecs[i].hold, waits);
    end

    // Reset in the middle of an operation.
    a_s0 = 8'hA5; a_s1 = 8'h5A; b_s0 = 8'hFF; b_s1 = 8'h0F;
    in_valid = 1'b1;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    tick();
    check("abort_busy_combine", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_in_ready_low", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    check("abort_seeded", 32'(dut.seeded), 32'd0);
    check("abort_lfsr", dut.lfsr, 32'd0);
    check("abort_operands", 32'(dut.op_a_s0 | dut.op_a_s1 | dut.op_b_s0 | dut.op_b_s1), 32'd0);
    check("abort_c", {16'd0, c_s0, c_s1}, 32'd0);

    send_seed(32'hACE1ACE1);
    for (int i = 0; i < 100; i++) begin
      logic [W-1:0] ra0, ra1, rb0, rb1;
      ra0 = W'($urandom); ra1 = W'($urandom); rb0 = W'($urandom); rb1 = W'($urandom);
      run_op(ra0, ra1, rb0, rb1, (ra0 ^ ra1) & (rb0 ^ rb1), i % 3, waits);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
